// File: rtl/sram_cmd_sequencer_if.sv
// rtl/sram_cmd_sequencer_if.sv - UART byte and SRAM request signals of the command sequencer
interface sram_cmd_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_ready;
   logic              sram_req;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_wdata;
   logic              sram_ack;
   logic [7:0]        sram_rdata;

   modport master (
      input  rx_data, rx_valid, tx_ready, sram_ack, sram_rdata,
      output tx_data, tx_start, sram_req, sram_we, sram_addr, sram_wdata
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, sram_ack, sram_rdata,
      input  tx_data, tx_start, sram_req, sram_we, sram_addr, sram_wdata
   );
endinterface

// File: rtl/sram_cmd_sequencer.sv
// rtl/sram_cmd_sequencer.sv - host frame assembler and SRAM/UART command executor
module sram_cmd_sequencer #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 120000
) (
   input  logic                 clk,
   input  logic                 rstn,
   sram_cmd_sequencer_if.master bus,
   output logic                 busy,
   output logic                 err
);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [7:0] CMD_ADDR     = 8'd1;
   localparam logic [7:0] CMD_LOAD     = 8'd2;
   localparam logic [7:0] CMD_WRITE    = 8'd3;
   localparam logic [7:0] CMD_READ     = 8'd4;
   localparam logic [7:0] CMD_READ_REQ = 8'd5;
   localparam logic [7:0] CMD_COUNT    = 8'd6;
   localparam logic [7:0] CMD_CONST    = 8'd7;

   typedef enum logic [2:0] {
      IDLE, DISPATCH, SRAM_WAIT, TX_WAIT_RDY, TX_WAIT_ACC, FILL
   } state_t;

   state_t            state, state_nx;
   logic [39:0]       frame_sr;
   logic [2:0]        byte_cnt;
   logic [TW-1:0]     tmr;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        data_reg;
   logic [7:0]        rd_reg;
   logic              we_reg;
   logic              fill_mode;
   logic              fill_const;
   logic [31:0]       fill_idx;
   logic [31:0]       fill_n;

   logic [7:0]  cmd;
   logic [31:0] payload;
   logic        timeout;
   logic        frame_done;
   logic        last_fill;

   function automatic logic cmd_ok(input logic [7:0] c);
      return (c >= CMD_ADDR) && (c <= CMD_CONST);
   endfunction

   assign cmd        = frame_sr[39:32];
   assign payload    = frame_sr[31:0];
   assign timeout    = (byte_cnt != 3'd0) && (tmr == TW'(TIMEOUT - 1));
   // Byte 0 of the completing frame is the command; it sits at [31:24] before the final shift.
   assign frame_done = (state == IDLE) && bus.rx_valid && !timeout && (byte_cnt == 3'd4)
                       && cmd_ok(frame_sr[31:24]);
   assign last_fill  = (fill_idx + 32'd1) == fill_n;

   assign bus.sram_req   = (state == SRAM_WAIT);
   assign bus.sram_we    = bus.sram_req & we_reg;
   assign bus.sram_addr  = addr_reg;
   assign bus.sram_wdata = (fill_mode && !fill_const) ? fill_idx[7:0] : data_reg;
   assign bus.tx_start   = (state == TX_WAIT_ACC);
   assign bus.tx_data    = rd_reg;
   assign busy           = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (frame_done) state_nx = DISPATCH;
         DISPATCH: begin
            case (cmd)
               CMD_WRITE, CMD_READ_REQ: state_nx = SRAM_WAIT;
               CMD_READ:                state_nx = TX_WAIT_RDY;
               CMD_COUNT, CMD_CONST:    state_nx = (payload == 32'd0) ? IDLE : SRAM_WAIT;
               default:                 state_nx = IDLE;
            endcase
         end
         SRAM_WAIT: if (bus.sram_ack) state_nx = (fill_mode && !last_fill) ? FILL : IDLE;
         FILL:        state_nx = SRAM_WAIT;
         TX_WAIT_RDY: if (bus.tx_ready)  state_nx = TX_WAIT_ACC;
         TX_WAIT_ACC: if (!bus.tx_ready) state_nx = IDLE;
         default:     state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         frame_sr   <= '0;
         byte_cnt   <= '0;
         tmr        <= '0;
         addr_reg   <= '0;
         data_reg   <= '0;
         rd_reg     <= '0;
         we_reg     <= 1'b0;
         fill_mode  <= 1'b0;
         fill_const <= 1'b0;
         fill_idx   <= '0;
         fill_n     <= '0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         if (state != IDLE) begin
            if (bus.rx_valid) err <= 1'b1;
         end else if (timeout) begin
            // A byte landing on the timeout cycle starts a fresh frame.
            err      <= 1'b1;
            tmr      <= '0;
            byte_cnt <= bus.rx_valid ? 3'd1 : 3'd0;
            if (bus.rx_valid) frame_sr <= {frame_sr[31:0], bus.rx_data};
         end else if (bus.rx_valid) begin
            frame_sr <= {frame_sr[31:0], bus.rx_data};
            tmr      <= '0;
            if (byte_cnt == 3'd4) begin
               byte_cnt <= 3'd0;
               if (!cmd_ok(frame_sr[31:24])) err <= 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 3'd1;
            end
         end else if (byte_cnt != 3'd0) begin
            tmr <= tmr + TW'(1);
         end

         case (state)
            DISPATCH: begin
               case (cmd)
                  CMD_ADDR: addr_reg <= payload[ADDR_W-1:0];
                  CMD_LOAD: data_reg <= payload[7:0];
                  CMD_WRITE: begin
                     we_reg    <= 1'b1;
                     fill_mode <= 1'b0;
                  end
                  CMD_READ_REQ: begin
                     we_reg    <= 1'b0;
                     fill_mode <= 1'b0;
                  end
                  CMD_COUNT, CMD_CONST: begin
                     we_reg     <= 1'b1;
                     fill_mode  <= 1'b1;
                     fill_const <= (cmd == CMD_CONST);
                     fill_idx   <= '0;
                     fill_n     <= payload;
                  end
                  default: ;
               endcase
            end
            SRAM_WAIT: begin
               if (bus.sram_ack) begin
                  if (!we_reg) rd_reg <= bus.sram_rdata;
                  if (fill_mode) begin
                     addr_reg <= addr_reg + ADDR_W'(1);
                     fill_idx <= fill_idx + 32'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// tb/tb_sram_cmd_sequencer.sv - directed vector bench for sram_cmd_sequencer
module tb_sram_cmd_sequencer;
   localparam int AW = 16;
   localparam int TO = 40;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic busy, err;

   always #5 clk = ~clk;

   sram_cmd_sequencer_if #(.ADDR_W(AW)) bus ();

   sram_cmd_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus),
      .busy (busy),
      .err  (err)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
   } txn_t;

   typedef struct {
      logic [7:0]    cmd;
      logic [31:0]   payload;
      int            ntx;
      logic          we;
      logic [AW-1:0] a0;
      logic [7:0]    d0;
      logic [AW-1:0] alast;
      logic [7:0]    dlast;
      int            nerr;
   } vec_t;

   txn_t       txlog[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         err_cnt = 0;
   int         viol = 0;
   int         tx_cnt = 0;
   int         lat = 2;
   logic [7:0] host_byte = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SRAM model: acks each request after lat cycles and logs it.
   initial begin : responder
      int dly;
      dly = 0;
      forever begin
         @(negedge clk);
         if (bus.sram_ack) begin
            bus.sram_ack = 1'b0;
         end else if (bus.sram_req) begin
            if (dly >= lat) begin
               bus.sram_ack = 1'b1;
               txlog.push_back('{bus.sram_we, bus.sram_addr, bus.sram_wdata});
               dly = 0;
            end else begin
               dly++;
            end
         end else begin
            dly = 0;
         end
      end
   end

   initial begin : monitor
      logic          p_req, p_we, p_tx;
      logic [AW-1:0] p_addr;
      logic [7:0]    p_wd;
      p_req = 1'b0; p_we = 1'b0; p_tx = 1'b0; p_addr = '0; p_wd = '0;
      forever begin
         @(posedge clk);
         #1;
         if (err) err_cnt++;
         if (bus.tx_start && !p_tx) begin
            tx_cnt++;
            host_byte = bus.tx_data;
         end
         if (bus.sram_req && p_req &&
             ({bus.sram_we, bus.sram_addr, bus.sram_wdata} != {p_we, p_addr, p_wd})) viol++;
         // ack sampled on the previous edge must have dropped the request
         if (bus.sram_ack && bus.sram_req) viol++;
         p_req = bus.sram_req; p_we = bus.sram_we; p_addr = bus.sram_addr;
         p_wd = bus.sram_wdata; p_tx = bus.tx_start;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [31:0] p);
      send_byte(c);
      send_byte(p[31:24]);
      send_byte(p[23:16]);
      send_byte(p[15:8]);
      send_byte(p[7:0]);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", busy, 0);
   endtask

   vec_t vecs[13];

   initial begin : main
      int e0, n;
      bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
      bus.sram_ack = 1'b0; bus.sram_rdata = 8'h5A;

      vecs[0]  = '{8'h01, 32'h0000_0001, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 0};
      vecs[1]  = '{8'h02, 32'h0000_00AA, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 0};
      vecs[2]  = '{8'h03, 32'h0000_0000, 1, 1'b1, 16'h0001, 8'hAA, 16'h0001, 8'hAA, 0};
      vecs[3]  = '{8'h05, 32'h0000_0000, 1, 1'b0, 16'h0001, 8'h00, 16'h0001, 8'h00, 0};
      vecs[4]  = '{8'h01, 32'h0000_FFFE, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 0};
      vecs[5]  = '{8'h06, 32'h0000_0004, 4, 1'b1, 16'hFFFE, 8'h00, 16'h0001, 8'h03, 0};
      vecs[6]  = '{8'h06, 32'h0000_0000, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 0};
      vecs[7]  = '{8'h03, 32'h0000_0000, 1, 1'b1, 16'h0002, 8'hAA, 16'h0002, 8'hAA, 0};
      vecs[8]  = '{8'h09, 32'h0000_0000, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 1};
      vecs[9]  = '{8'h02, 32'h0000_0033, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 0};
      vecs[10] = '{8'h01, 32'h0000_0010, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 0};
      vecs[11] = '{8'h07, 32'h0000_0003, 3, 1'b1, 16'h0010, 8'h33, 16'h0012, 8'h33, 0};
      vecs[12] = '{8'h03, 32'h0000_0000, 1, 1'b1, 16'h0013, 8'h33, 16'h0013, 8'h33, 0};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_req", bus.sram_req, 0);
      chk("rst_we", bus.sram_we, 0);
      chk("rst_addr", bus.sram_addr, 0);
      chk("rst_wdata", bus.sram_wdata, 0);
      chk("rst_tx_start", bus.tx_start, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      rstn = 1'b1;

      foreach (vecs[i]) begin
         txlog.delete();
         e0 = err_cnt;
         send_frame(vecs[i].cmd, vecs[i].payload);
         wait_idle();
         chk($sformatf("v%0d_ntx", i), txlog.size(), vecs[i].ntx);
         chk($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].nerr);
         if (vecs[i].ntx > 0 && txlog.size() > 0) begin
            chk($sformatf("v%0d_we", i), txlog[0].we, vecs[i].we);
            chk($sformatf("v%0d_a0", i), txlog[0].addr, vecs[i].a0);
            chk($sformatf("v%0d_alast", i), txlog[txlog.size()-1].addr, vecs[i].alast);
            if (vecs[i].we) begin
               chk($sformatf("v%0d_d0", i), txlog[0].wdata, vecs[i].d0);
               chk($sformatf("v%0d_dlast", i), txlog[txlog.size()-1].wdata, vecs[i].dlast);
            end
         end
      end
      chk("count_mid_addr", (txlog.size() == 1) ? 1 : 0, 1);

      // READ returns rd_reg (0x5A from the earlier READ_REQ) only once tx_ready is high
      send_frame(8'h04, 32'h0);
      repeat (4) @(negedge clk);
      chk("rd_hold_start", bus.tx_start, 0);
      chk("rd_hold_busy", busy, 1);
      bus.tx_ready = 1'b1;
      @(negedge clk);
      chk("rd_tx_start", bus.tx_start, 1);
      chk("rd_tx_data", bus.tx_data, 8'h5A);
      bus.tx_ready = 1'b0;
      @(negedge clk);
      chk("rd_start_drop", bus.tx_start, 0);
      chk("rd_busy_drop", busy, 0);
      chk("rd_host_byte", host_byte, 8'h5A);
      chk("rd_tx_cnt", tx_cnt, 1);

      // partial frame then timeout gap
      txlog.delete();
      e0 = err_cnt;
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (TO + 10) @(negedge clk);
      chk("to_err", err_cnt - e0, 1);
      send_frame(8'h02, 32'h0000_0077);
      wait_idle();
      chk("to_err_after", err_cnt - e0, 1);
      chk("to_no_sram", txlog.size(), 0);
      send_frame(8'h03, 32'h0);
      wait_idle();
      chk("to_wr_ntx", txlog.size(), 1);
      if (txlog.size() > 0) begin
         chk("to_wr_data", txlog[0].wdata, 8'h77);
         chk("to_wr_addr", txlog[0].addr, 16'h0013);
      end

      // stray byte during a CONST fill
      lat = 3;
      send_frame(8'h01, 32'h0000_0020);
      wait_idle();
      txlog.delete();
      e0 = err_cnt;
      send_frame(8'h07, 32'h0000_0005);
      repeat (3) @(negedge clk);
      send_byte(8'hC3);
      wait_idle();
      chk("fill_ntx", txlog.size(), 5);
      chk("fill_err", err_cnt - e0, 1);
      if (txlog.size() == 5) begin
         chk("fill_alast", txlog[4].addr, 16'h0024);
         chk("fill_dlast", txlog[4].wdata, 8'h77);
      end
      txlog.delete();
      send_frame(8'h03, 32'h0);
      wait_idle();
      chk("fill_post_ntx", txlog.size(), 1);
      if (txlog.size() > 0) chk("fill_post_addr", txlog[0].addr, 16'h0025);

      // reset in the middle of a COUNT
      send_frame(8'h01, 32'h0000_0100);
      wait_idle();
      send_frame(8'h06, 32'h0000_000A);
      n = 0;
      while (!bus.sram_req && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_req_seen", bus.sram_req, 1);
      rstn = 1'b0;
      @(negedge clk);
      chk("rst_mid_req", bus.sram_req, 0);
      chk("rst_mid_busy", busy, 0);
      rstn = 1'b1;
      @(negedge clk);
      txlog.delete();
      send_frame(8'h03, 32'h0);
      wait_idle();
      chk("rst_wr_ntx", txlog.size(), 1);
      if (txlog.size() > 0) begin
         chk("rst_wr_addr", txlog[0].addr, 16'h0000);
         chk("rst_wr_data", txlog[0].wdata, 8'h00);
      end

      chk("protocol_viol", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
